mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single synchronous memory.
// Each access takes three cycles: grant/drive (ACCESS), capture (DONE), completion pulse.
module mem_arbiter #(
   parameter int unsigned N = 16,
   parameter int unsigned A = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         req0,
   input  logic         req1,
   input  logic         we0,
   input  logic         we1,
   input  logic [A-1:0] addr0,
   input  logic [A-1:0] addr1,
   input  logic [N-1:0] wdata0,
   input  logic [N-1:0] wdata1,
   output logic         gnt0,
   output logic         gnt1,
   output logic         done0,
   output logic         done1,
   output logic [N-1:0] rdata0,
   output logic [N-1:0] rdata1,
   output logic [A-1:0] Address,
   output logic [N-1:0] Dout,
   input  logic [N-1:0] Din,
   output logic         RW
);

   typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

   state_e         state_q, state_d;
   logic           ptr_q, ptr_d;
   logic           owner_q, owner_d;
   logic           rd_q, rd_d;
   logic [A-1:0]   addr_q, addr_d;
   logic [N-1:0]   dout_q, dout_d;
   logic           rw_q, rw_d;
   logic           gnt0_q, gnt0_d;
   logic           gnt1_q, gnt1_d;
   logic           done0_q, done0_d;
   logic           done1_q, done1_d;
   logic [N-1:0]   rdata0_q, rdata0_d;
   logic [N-1:0]   rdata1_q, rdata1_d;
   logic           pick;
   logic           pick_we;

   // Pointer only matters on a tie; a lone requester always wins.
   always_comb begin
      pick    = (req0 && req1) ? ptr_q : req1;
      pick_we = pick ? we1 : we0;
   end

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      owner_d  = owner_q;
      rd_d     = rd_q;
      addr_d   = addr_q;
      dout_d   = dout_q;
      rw_d     = 1'b1;
      gnt0_d   = 1'b0;
      gnt1_d   = 1'b0;
      done0_d  = 1'b0;
      done1_d  = 1'b0;
      rdata0_d = rdata0_q;
      rdata1_d = rdata1_q;
      unique case (state_q)
         StIdle: begin
            if (req0 || req1) begin
               addr_d  = pick ? addr1 : addr0;
               dout_d  = pick ? wdata1 : wdata0;
               rw_d    = ~pick_we;
               rd_d    = ~pick_we;
               owner_d = pick;
               ptr_d   = ~pick;
               gnt0_d  = ~pick;
               gnt1_d  = pick;
               state_d = StAccess;
            end
         end
         StAccess: begin
            state_d = StDone;
         end
         StDone: begin
            // Din now reflects the address the memory sampled at the end of ACCESS.
            if (rd_q) begin
               if (owner_q) rdata1_d = Din;
               else         rdata0_d = Din;
            end
            done0_d = ~owner_q;
            done1_d = owner_q;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= StIdle;
         ptr_q    <= 1'b0;
         owner_q  <= 1'b0;
         rd_q     <= 1'b0;
         addr_q   <= '0;
         dout_q   <= '0;
         rw_q     <= 1'b1;
         gnt0_q   <= 1'b0;
         gnt1_q   <= 1'b0;
         done0_q  <= 1'b0;
         done1_q  <= 1'b0;
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         owner_q  <= owner_d;
         rd_q     <= rd_d;
         addr_q   <= addr_d;
         dout_q   <= dout_d;
         rw_q     <= rw_d;
         gnt0_q   <= gnt0_d;
         gnt1_q   <= gnt1_d;
         done0_q  <= done0_d;
         done1_q  <= done1_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
      end
   end

   assign gnt0    = gnt0_q;
   assign gnt1    = gnt1_q;
   assign done0   = done0_q;
   assign done1   = done1_q;
   assign rdata0  = rdata0_q;
   assign rdata1  = rdata1_q;
   assign Address = addr_q;
   assign Dout    = dout_q;
   assign RW      = rw_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios, then random traffic checked against a
// transaction-level round-robin/memory model.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0, req1, we0, we1;
   logic [15:0] addr0, addr1, wdata0, wdata1;
   logic        gnt0, gnt1, done0, done1;
   logic [15:0] rdata0, rdata1, Address, Dout;
   logic [15:0] Din;
   logic        RW;

   int checks   = 0;
   int failures = 0;

   logic [15:0] mem [0:65535];
   logic [15:0] ref_mem [0:63];

   mem_arbiter #(.N(16), .A(16)) dut (
      .clk    (clk),
      .reset  (reset),
      .req0   (req0),
      .req1   (req1),
      .we0    (we0),
      .we1    (we1),
      .addr0  (addr0),
      .addr1  (addr1),
      .wdata0 (wdata0),
      .wdata1 (wdata1),
      .gnt0   (gnt0),
      .gnt1   (gnt1),
      .done0  (done0),
      .done1  (done1),
      .rdata0 (rdata0),
      .rdata1 (rdata1),
      .Address(Address),
      .Dout   (Dout),
      .Din    (Din),
      .RW     (RW)
   );

   always #5 clk = ~clk;

   // Synchronous memory: writes when RW=0, read data valid the cycle after sampling.
   always @(posedge clk) begin
      if (!RW) mem[Address] <= Dout;
      Din <= mem[Address];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   logic        preq [2];
   logic        pwe [2];
   logic [15:0] paddr [2];
   logic [15:0] pwdata [2];
   logic [15:0] exp_rdata [2];
   logic        ptr;
   logic        w;
   logic [15:0] rexp;

   task automatic drive();
      req0 = preq[0]; we0 = pwe[0]; addr0 = paddr[0]; wdata0 = pwdata[0];
      req1 = preq[1]; we1 = pwe[1]; addr1 = paddr[1]; wdata1 = pwdata[1];
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = '0;
      for (int i = 0; i < 64; i++) begin
         mem[i]     = 16'(i * 16'h0101);
         ref_mem[i] = 16'(i * 16'h0101);
      end
      reset = 1'b1;
      req0 = 0; req1 = 0; we0 = 0; we1 = 0;
      addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
      tick();
      tick();
      chk("rst_gnt0", gnt0, 0);
      chk("rst_gnt1", gnt1, 0);
      chk("rst_done0", done0, 0);
      chk("rst_done1", done1, 0);
      chk("rst_rw", RW, 1);
      chk("rst_addr", Address, 0);
      chk("rst_dout", Dout, 0);
      chk("rst_rdata0", rdata0, 0);
      chk("rst_rdata1", rdata1, 0);
      reset = 1'b0;
      tick();

      // Write 0xBEEF to 0x0010 from port 0.
      req0 = 1; we0 = 1; addr0 = 16'h0010; wdata0 = 16'hBEEF;
      tick();
      chk("wr_gnt0", gnt0, 1);
      chk("wr_gnt1", gnt1, 0);
      chk("wr_rw_c1", RW, 0);
      chk("wr_addr_c1", Address, 16'h0010);
      chk("wr_dout_c1", Dout, 16'hBEEF);
      req0 = 0;
      tick();
      chk("wr_gnt0_c2", gnt0, 0);
      chk("wr_rw_c2", RW, 1);
      chk("wr_addr_c2", Address, 16'h0010);
      chk("wr_done0_c2", done0, 0);
      tick();
      chk("wr_done0_c3", done0, 1);
      chk("wr_rw_c3", RW, 1);
      chk("wr_mem", mem[16'h0010], 16'hBEEF);
      ref_mem[16'h10] = 16'hBEEF;

      // Read it back from port 1.
      req1 = 1; we1 = 0; addr1 = 16'h0010;
      tick();
      chk("rd_gnt1", gnt1, 1);
      chk("rd_gnt0", gnt0, 0);
      chk("rd_done0_c1", done0, 0);
      chk("rd_rw_c1", RW, 1);
      chk("rd_addr_c1", Address, 16'h0010);
      req1 = 0;
      tick();
      chk("rd_rw_c2", RW, 1);
      chk("rd_done1_c2", done1, 0);
      tick();
      chk("rd_done1_c3", done1, 1);
      chk("rd_done0_c3", done0, 0);
      chk("rd_rdata1", rdata1, 16'hBEEF);
      chk("rd_rdata0", rdata0, 0);

      // Request from port 1 arriving while port 0 is in ACCESS waits for IDLE.
      req0 = 1; we0 = 1; addr0 = 16'h0021; wdata0 = 16'h5A5A;
      tick();
      chk("late_gnt0", gnt0, 1);
      req0 = 0;
      req1 = 1; we1 = 0; addr1 = 16'h0021;
      tick();
      chk("late_gnt1_c2", gnt1, 0);
      tick();
      chk("late_gnt1_c3", gnt1, 0);
      chk("late_done0_c3", done0, 1);
      tick();
      chk("late_gnt1_c4", gnt1, 1);
      chk("late_addr_c4", Address, 16'h0021);
      req1 = 0;
      tick();
      tick();
      chk("late_done1", done1, 1);
      chk("late_rdata1", rdata1, 16'h5A5A);
      ref_mem[16'h21] = 16'h5A5A;

      // Reset during ACCESS of a write abandons it.
      req0 = 1; we0 = 1; addr0 = 16'h0020; wdata0 = 16'h1234;
      tick();
      chk("abort_gnt0", gnt0, 1);
      chk("abort_rw_pre", RW, 0);
      #1 reset = 1'b1;
      #1;
      chk("abort_rw", RW, 1);
      chk("abort_addr", Address, 0);
      chk("abort_dout", Dout, 0);
      chk("abort_gnt0_rst", gnt0, 0);
      chk("abort_rdata1", rdata1, 0);
      req0 = 0;
      tick();
      reset = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("abort_no_done0", done0, 0);
      end
      chk("abort_mem", mem[16'h0020], 16'h2020);

      // Both ports hold read requests from reset: grants alternate every 3 cycles.
      do_reset();
      req0 = 1; we0 = 0; addr0 = 16'h0001;
      req1 = 1; we1 = 0; addr1 = 16'h0002;
      for (int c = 1; c <= 12; c++) begin
         logic g, gp, d, dp;
         tick();
         g  = ((c - 1) % 3) == 0;
         gp = (((c - 1) / 3) % 2) == 1;
         d  = (c >= 3) && (((c - 3) % 3) == 0);
         dp = (((c - 3) / 3) % 2) == 1;
         chk($sformatf("alt_gnt0_c%0d", c), gnt0, g && !gp);
         chk($sformatf("alt_gnt1_c%0d", c), gnt1, g && gp);
         chk($sformatf("alt_done0_c%0d", c), done0, d && !dp);
         chk($sformatf("alt_done1_c%0d", c), done1, d && dp);
         if (d && !dp) chk($sformatf("alt_rdata0_c%0d", c), rdata0, 16'h0101);
         if (d && dp)  chk($sformatf("alt_rdata1_c%0d", c), rdata1, 16'h0202);
      end
      req0 = 0; req1 = 0;
      tick();
      chk("alt_idle_gnt", {gnt0, gnt1}, 0);

      // Random traffic against a transaction-level model.
      do_reset();
      ptr = 1'b0;
      exp_rdata[0] = '0;
      exp_rdata[1] = '0;
      for (int p = 0; p < 2; p++) begin
         preq[p] = 0; pwe[p] = 0; paddr[p] = 0; pwdata[p] = 0;
      end
      for (int t = 0; t < 40; t++) begin
         for (int p = 0; p < 2; p++) begin
            if (!preq[p] && $urandom_range(1, 0) == 1) begin
               preq[p]   = 1;
               pwe[p]    = 1'($urandom_range(1, 0));
               paddr[p]  = 16'($urandom_range(63, 0));
               pwdata[p] = 16'($urandom);
            end
         end
         if (!preq[0] && !preq[1]) begin
            int p;
            p = int'($urandom_range(1, 0));
            preq[p]   = 1;
            pwe[p]    = 1'($urandom_range(1, 0));
            paddr[p]  = 16'($urandom_range(63, 0));
            pwdata[p] = 16'($urandom);
         end
         drive();
         w = (preq[0] && preq[1]) ? ptr : preq[1];
         tick();
         chk($sformatf("rnd%0d_gnt0", t), gnt0, !w);
         chk($sformatf("rnd%0d_gnt1", t), gnt1, w);
         chk($sformatf("rnd%0d_addr", t), Address, paddr[w]);
         chk($sformatf("rnd%0d_rw", t), RW, !pwe[w]);
         if (pwe[w]) chk($sformatf("rnd%0d_dout", t), Dout, pwdata[w]);
         rexp = ref_mem[paddr[w][5:0]];
         if (pwe[w]) ref_mem[paddr[w][5:0]] = pwdata[w];
         else        exp_rdata[w] = rexp;
         ptr = !w;
         preq[w] = 0;
         drive();
         tick();
         chk($sformatf("rnd%0d_rw_c2", t), RW, 1);
         chk($sformatf("rnd%0d_gnt_c2", t), {gnt0, gnt1}, 0);
         tick();
         chk($sformatf("rnd%0d_done0", t), done0, !w);
         chk($sformatf("rnd%0d_done1", t), done1, w);
         chk($sformatf("rnd%0d_rdata0", t), rdata0, exp_rdata[0]);
         chk($sformatf("rnd%0d_rdata1", t), rdata1, exp_rdata[1]);
      end
      preq[0] = 0; preq[1] = 0;
      drive();
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
